// File: rtl/lap_stopwatch_if.sv
// Button/mode inputs and BCD display outputs of the lap stopwatch.
// The core attaches to the slave side; whatever drives the buttons uses master.
interface lap_stopwatch_if #(
    parameter int NUM_LAPS = 4
);
    localparam int LSEL_W = $clog2(NUM_LAPS);

    logic              start_stop;
    logic              lap;
    logic              clear;
    logic              inc_min;
    logic              count_down;
    logic [LSEL_W-1:0] lap_sel;
    logic [23:0]       time_bcd;
    logic [23:0]       lap_bcd;
    logic [LSEL_W:0]   lap_count;
    logic              running;
    logic              zero;
    logic              expired;

    modport master (
        output start_stop, lap, clear, inc_min, count_down, lap_sel,
        input  time_bcd, lap_bcd, lap_count, running, zero, expired
    );

    modport slave (
        input  start_stop, lap, clear, inc_min, count_down, lap_sel,
        output time_bcd, lap_bcd, lap_count, running, zero, expired
    );
endinterface

// File: rtl/lap_stopwatch.sv
// BCD min:sec:centisecond stopwatch, counting up or down, with a circular
// lap buffer and a one-cycle expiry pulse.
module lap_stopwatch #(
    parameter int CLK_HZ   = 100000000,
    parameter int TICK_HZ  = 100,
    parameter int NUM_LAPS = 4,
    parameter int MAX_MIN  = 99
) (
    input logic            clock,
    input logic            rst,
    lap_stopwatch_if.slave bus
);
    localparam int DIV    = CLK_HZ / TICK_HZ;
    localparam int PW     = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int LSEL_W = $clog2(NUM_LAPS);
    localparam int CW     = LSEL_W + 1;

    localparam logic [7:0]    MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
    localparam logic [23:0]   MAX_TIME    = {MAX_MIN_BCD, 16'h5999};
    localparam logic [CW-1:0] LAP_FULL    = CW'(NUM_LAPS);
    localparam logic [PW-1:0] PRE_TERM    = PW'(DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;

    state_t            state_q;
    logic              mode_q;
    logic [23:0]       time_q;
    logic [PW-1:0]     presc_q;
    logic [23:0]       laps_q [NUM_LAPS];
    logic [LSEL_W-1:0] wr_ptr_q;
    logic [CW-1:0]     lap_cnt_q;
    logic              expired_q;
    logic              ss_prev_q, lap_prev_q, clr_prev_q, inc_prev_q;

    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] r;
        logic        c;
        logic [3:0]  lim;
        r = t;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = (i == 3) ? 4'd5 : 4'd9;
            if (c) begin
                if (r[i*4 +: 4] == lim) r[i*4 +: 4] = 4'd0;
                else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [23:0] bcd_dec(input logic [23:0] t);
        logic [23:0] r;
        logic        b;
        logic [3:0]  lim;
        r = t;
        b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = (i == 3) ? 4'd5 : 4'd9;
            if (b) begin
                if (r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = lim;
                else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Minute preset wraps from MAX_MIN back to 0.
    function automatic logic [7:0] min_inc(input logic [7:0] m);
        if (m == MAX_MIN_BCD)   return 8'h00;
        else if (m[3:0] == 4'd9) return {m[7:4] + 4'd1, 4'd0};
        else                    return {m[7:4], m[3:0] + 4'd1};
    endfunction

    logic              ss_e, lap_e, clr_e, inc_e, tick;
    logic [23:0]       time_up_d, time_dn_d;
    logic [7:0]        min_d;
    logic [LSEL_W-1:0] rd_idx;

    assign ss_e      = bus.start_stop & ~ss_prev_q;
    assign lap_e     = bus.lap & ~lap_prev_q;
    assign clr_e     = bus.clear & ~clr_prev_q;
    assign inc_e     = bus.inc_min & ~inc_prev_q;
    assign tick      = (state_q == S_RUN) && (presc_q == PRE_TERM);
    assign time_up_d = bcd_inc(time_q);
    assign time_dn_d = bcd_dec(time_q);
    assign min_d     = min_inc(time_q[23:16]);
    assign rd_idx    = wr_ptr_q - LSEL_W'(1) - bus.lap_sel;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            time_q     <= '0;
            presc_q    <= '0;
            wr_ptr_q   <= '0;
            lap_cnt_q  <= '0;
            expired_q  <= 1'b0;
            ss_prev_q  <= 1'b0;
            lap_prev_q <= 1'b0;
            clr_prev_q <= 1'b0;
            inc_prev_q <= 1'b0;
            for (int i = 0; i < NUM_LAPS; i++) laps_q[i] <= '0;
        end else begin
            ss_prev_q  <= bus.start_stop;
            lap_prev_q <= bus.lap;
            clr_prev_q <= bus.clear;
            inc_prev_q <= bus.inc_min;
            expired_q  <= 1'b0;
            if (clr_e) begin
                state_q   <= S_IDLE;
                mode_q    <= 1'b0;
                time_q    <= '0;
                presc_q   <= '0;
                wr_ptr_q  <= '0;
                lap_cnt_q <= '0;
                for (int i = 0; i < NUM_LAPS; i++) laps_q[i] <= '0;
            end else begin
                // Lap always captures the pre-tick, pre-stop time.
                if (lap_e && state_q == S_RUN) begin
                    laps_q[wr_ptr_q] <= time_q;
                    wr_ptr_q         <= wr_ptr_q + LSEL_W'(1);
                    if (lap_cnt_q != LAP_FULL) lap_cnt_q <= lap_cnt_q + CW'(1);
                end
                case (state_q)
                    S_IDLE: begin
                        mode_q <= bus.count_down;
                        if (inc_e) time_q[23:16] <= min_d;
                        if (ss_e && !(bus.count_down && time_q == 24'h0)) begin
                            state_q <= S_RUN;
                            presc_q <= '0;
                        end
                    end
                    S_RUN: begin
                        // Stopping freezes the prescaler so no tick is lost across the pause.
                        if (ss_e) state_q <= S_PAUSE;
                        else if (tick) begin
                            presc_q <= '0;
                            if (mode_q) begin
                                if (time_q != 24'h0) time_q <= time_dn_d;
                                if (time_q == 24'h0 || time_dn_d == 24'h0) begin
                                    state_q   <= S_EXPIRED;
                                    expired_q <= 1'b1;
                                end
                            end else begin
                                if (time_q != MAX_TIME) time_q <= time_up_d;
                                if (time_q == MAX_TIME || time_up_d == MAX_TIME) begin
                                    state_q   <= S_EXPIRED;
                                    expired_q <= 1'b1;
                                end
                            end
                        end else presc_q <= presc_q + PW'(1);
                    end
                    S_PAUSE: begin
                        if (inc_e) time_q[23:16] <= min_d;
                        if (ss_e) state_q <= S_RUN;
                    end
                    S_EXPIRED: begin
                        if (ss_e) state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.time_bcd  = time_q;
    assign bus.lap_bcd   = ({1'b0, bus.lap_sel} < lap_cnt_q) ? laps_q[rd_idx] : 24'h0;
    assign bus.lap_count = lap_cnt_q;
    assign bus.running   = (state_q == S_RUN);
    assign bus.zero      = (time_q == 24'h0);
    assign bus.expired   = expired_q;
endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: divide-by-10 instance for run/pause/lap scenarios,
// divide-by-2 MAX_MIN=1 instance for the long expiry and wrap scenarios.
module tb_lap_stopwatch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lap_stopwatch_if #(.NUM_LAPS(4)) ifa ();
    lap_stopwatch_if #(.NUM_LAPS(4)) ifb ();

    lap_stopwatch #(.CLK_HZ(1000), .TICK_HZ(100), .NUM_LAPS(4), .MAX_MIN(99))
        dut_a (.clock(clk), .rst(rst), .bus(ifa));
    lap_stopwatch #(.CLK_HZ(200), .TICK_HZ(100), .NUM_LAPS(4), .MAX_MIN(1))
        dut_b (.clock(clk), .rst(rst), .bus(ifb));

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [1:0]  sel;
        logic [23:0] exp;
    } lapvec_t;

    exp_t    sb_q[$];
    lapvec_t lv[4];
    int      n_total = 0;
    int      n_pass  = 0;

    task automatic expect_v(input string n, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic compare(input logic [31:0] act);
        exp_t e;
        n_total++;
        if (sb_q.size() == 0) begin
            $display("FAIL scoreboard_empty: got %h with no expectation queued", act);
        end else begin
            e = sb_q.pop_front();
            if (act === e.val) n_pass++;
            else $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] v);
        expect_v(n, v);
        compare(act);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_a(input bit ss, input bit lp, input bit cl, input bit inc);
        @(negedge clk);
        ifa.start_stop = ss; ifa.lap = lp; ifa.clear = cl; ifa.inc_min = inc;
        @(negedge clk);
        ifa.start_stop = 0; ifa.lap = 0; ifa.clear = 0; ifa.inc_min = 0;
    endtask

    task automatic press_b(input bit ss, input bit lp, input bit cl, input bit inc);
        @(negedge clk);
        ifb.start_stop = ss; ifb.lap = lp; ifb.clear = cl; ifb.inc_min = inc;
        @(negedge clk);
        ifb.start_stop = 0; ifb.lap = 0; ifb.clear = 0; ifb.inc_min = 0;
    endtask

    initial begin
        lv[0] = '{2'd0, 24'h000060};
        lv[1] = '{2'd1, 24'h000050};
        lv[2] = '{2'd2, 24'h000040};
        lv[3] = '{2'd3, 24'h000030};

        ifa.start_stop = 0; ifa.lap = 0; ifa.clear = 0; ifa.inc_min = 0;
        ifa.count_down = 0; ifa.lap_sel = '0;
        ifb.start_stop = 0; ifb.lap = 0; ifb.clear = 0; ifb.inc_min = 0;
        ifb.count_down = 0; ifb.lap_sel = '0;
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(1);

        chk("rst_time",    32'(ifa.time_bcd),  32'h0);
        chk("rst_zero",    32'(ifa.zero),      32'd1);
        chk("rst_running", 32'(ifa.running),   32'd0);
        chk("rst_expired", 32'(ifa.expired),   32'd0);
        chk("rst_lapcnt",  32'(ifa.lap_count), 32'd0);
        chk("rst_time_b",  32'(ifb.time_bcd),  32'h0);

        // Run up for 100 ticks of 10 cycles each.
        press_a(1, 0, 0, 0);
        expect_v("up_time", 32'h000100);
        wait_cyc(1000);
        compare(32'(ifa.time_bcd));
        chk("up_running", 32'(ifa.running), 32'd1);
        chk("up_zero",    32'(ifa.zero),    32'd0);

        // Pause then resume: exactly three more ticks in 30 cycles.
        press_a(1, 0, 0, 0);
        expect_v("pause_time", 32'h000100);
        wait_cyc(500);
        compare(32'(ifa.time_bcd));
        chk("pause_running", 32'(ifa.running), 32'd0);
        press_a(1, 0, 0, 0);
        expect_v("resume_time", 32'h000103);
        wait_cyc(30);
        compare(32'(ifa.time_bcd));

        // Lap buffer: six laps at 0.10 s spacing into four slots.
        press_a(0, 0, 1, 0);
        chk("clr_time",    32'(ifa.time_bcd), 32'h0);
        chk("clr_running", 32'(ifa.running),  32'd0);
        press_a(1, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            wait_cyc(k == 0 ? 100 : 99);
            press_a(0, 1, 0, 0);
            if (k == 1) begin
                chk("lapcnt_2", 32'(ifa.lap_count), 32'd2);
                ifa.lap_sel = 2'd2;
                #1;
                chk("lap_sel_beyond_count", 32'(ifa.lap_bcd), 32'h0);
                ifa.lap_sel = 2'd0;
            end
        end
        chk("lapcnt_sat", 32'(ifa.lap_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            ifa.lap_sel = lv[i].sel;
            expect_v($sformatf("lap_sel_%0d", i), 32'(lv[i].exp));
            #1;
            compare(32'(ifa.lap_bcd));
        end
        ifa.lap_sel = 2'd0;

        // Lap and stop on the same edge, then clear with lap held.
        press_a(0, 0, 1, 0);
        press_a(1, 0, 0, 0);
        wait_cyc(570);
        press_a(1, 1, 0, 0);
        #1;
        chk("sim_lap0",    32'(ifa.lap_bcd),   32'h000057);
        chk("sim_lapcnt",  32'(ifa.lap_count), 32'd1);
        chk("sim_running", 32'(ifa.running),   32'd0);
        expect_v("sim_time_held", 32'h000057);
        wait_cyc(50);
        compare(32'(ifa.time_bcd));
        press_a(0, 1, 1, 0);
        #1;
        chk("clr2_time",   32'(ifa.time_bcd),  32'h0);
        chk("clr2_lapcnt", 32'(ifa.lap_count), 32'd0);
        chk("clr2_lapbcd", 32'(ifa.lap_bcd),   32'h0);
        chk("clr2_zero",   32'(ifa.zero),      32'd1);

        // Minute preset wraps at MAX_MIN=1, then up-count saturates at 01:59.99.
        press_b(0, 0, 0, 1);
        chk("inc1_time", 32'(ifb.time_bcd), 32'h010000);
        press_b(0, 0, 0, 1);
        chk("inc_wrap_time", 32'(ifb.time_bcd), 32'h000000);
        press_b(1, 0, 0, 0);
        expect_v("sat_pre_time", 32'h015998);
        wait_cyc(23997);
        compare(32'(ifb.time_bcd));
        chk("sat_pre_expired", 32'(ifb.expired), 32'd0);
        chk("sat_pre_running", 32'(ifb.running), 32'd1);
        wait_cyc(1);
        chk("sat_time",    32'(ifb.time_bcd), 32'h015999);
        chk("sat_expired", 32'(ifb.expired),  32'd1);
        chk("sat_running", 32'(ifb.running),  32'd0);
        wait_cyc(1);
        chk("sat_pulse_end", 32'(ifb.expired), 32'd0);
        expect_v("sat_hold", 32'h015999);
        wait_cyc(20);
        compare(32'(ifb.time_bcd));
        press_b(0, 0, 0, 1);
        chk("inc_ignored_expired", 32'(ifb.time_bcd), 32'h015999);
        press_b(1, 0, 0, 0);
        press_b(0, 0, 0, 1);
        chk("idle_after_expired", 32'(ifb.time_bcd), 32'h005999);

        // Count down from 01:00.00 to expiry.
        press_b(0, 0, 1, 0);
        ifb.count_down = 1'b1;
        press_b(1, 0, 0, 0);
        chk("down_zero_start_ignored", 32'(ifb.running), 32'd0);
        press_b(0, 0, 0, 1);
        chk("down_preset", 32'(ifb.time_bcd), 32'h010000);
        press_b(1, 0, 0, 0);
        chk("down_running", 32'(ifb.running), 32'd1);
        expect_v("down_pre_time", 32'h000001);
        wait_cyc(11999);
        compare(32'(ifb.time_bcd));
        chk("down_pre_expired", 32'(ifb.expired), 32'd0);
        wait_cyc(1);
        chk("down_time",    32'(ifb.time_bcd), 32'h0);
        chk("down_zero",    32'(ifb.zero),     32'd1);
        chk("down_expired", 32'(ifb.expired),  32'd1);
        chk("down_running", 32'(ifb.running),  32'd0);
        wait_cyc(1);
        chk("down_pulse_end", 32'(ifb.expired), 32'd0);
        press_b(1, 0, 0, 0);
        press_b(0, 0, 0, 1);
        chk("down_back_idle", 32'(ifb.time_bcd), 32'h010000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
